// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-requester round-robin arbiter with registered, held grants
// Ports: clk, rst (sync active-high), req[7:0] requests, done owner release strobe,
//        gnt[7:0] one-hot grant, gnt_idx owner index, gnt_valid grant active, timeout forced-release pulse.
// Define ARB_TIMEOUT_EN to bound each grant to MAX_HOLD cycles; otherwise timeout is tied 0.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nxt;
  logic [2:0] ptr, ptr_nxt, idx_nxt, win;
  logic [7:0] gnt_nxt;
  logic found, rel_norm, force_rel, rel;
  // Scan r upward from bit s with wraparound; returns {found, index}.
  function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] s);
    logic [3:0] p;
    p = '0;
    for (int i = 7; i >= 0; i--)
      if (r[s + 3'(i)]) p = {1'b1, s + 3'(i)};
    return p;
  endfunction
  `ifdef ARB_TIMEOUT_EN
  logic [7:0] hold;
  logic tmo;
  assign force_rel = (state == GRANT) && !rel_norm && (hold == 8'(MAX_HOLD - 1));
  assign timeout = tmo;
  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
      tmo  <= 1'b0;
    end else begin
      hold <= (state == GRANT && !rel) ? hold + 8'd1 : 8'd0;
      tmo  <= force_rel;
    end
  end
  `else
  assign force_rel = 1'b0;
  assign timeout = 1'b0;
  `endif
  always_comb begin
    rel_norm = (state == GRANT) && (done || !req[gnt_idx]);
    rel = rel_norm || force_rel;
    // On release the releasing owner is masked out so it always sees at least one idle cycle.
    {found, win} = pick(rel ? req & ~(8'b1 << gnt_idx) : req, rel ? gnt_idx + 3'd1 : ptr);
    ptr_nxt = rel ? gnt_idx + 3'd1 : ptr;
    state_nxt = state;
    gnt_nxt = gnt;
    idx_nxt = gnt_idx;
    if (state == IDLE || rel) begin
      state_nxt = found ? GRANT : IDLE;
      gnt_nxt = found ? 8'b1 << win : 8'd0;
      idx_nxt = found ? win : gnt_idx;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      gnt       <= gnt_nxt;
      gnt_idx   <= idx_nxt;
      gnt_valid <= state_nxt == GRANT;
    end
  end
endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed self-checking bench for rr_arbiter8
module tb_rr_arbiter8;
  logic clk = 1'b0;
  logic rst, done;
  logic [7:0] req, gnt;
  logic [2:0] gnt_idx;
  logic gnt_valid, timeout;
  int total = 0;
  int bad = 0;
  rr_arbiter8 #(
  `ifdef ARB_TIMEOUT_EN
    .MAX_HOLD(4)
  `else
    .MAX_HOLD(16)
  `endif
  ) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1; req = 8'h00; done = 1'b0;
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; req = 8'h00; done = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total++;
    if (gnt !== 8'h00 || gnt_idx !== 3'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL reset_state gnt=%h idx=%0d valid=%b tmo=%b want 00/0/0/0", gnt, gnt_idx, gnt_valid, timeout);
    end
  endtask
  task automatic test_reset_mid_grant();
    req = 8'h40; tick();
    total++;
    if (gnt !== 8'h40 || gnt_idx !== 3'd6) begin bad++; $display("FAIL rmg_first gnt=%h idx=%0d want 40/6", gnt, gnt_idx); end
    req = 8'h00; tick();
    req = 8'h08; tick();
    total++;
    if (gnt !== 8'h08 || gnt_idx !== 3'd3 || gnt_valid !== 1'b1) begin bad++; $display("FAIL rmg_owner3 gnt=%h idx=%0d valid=%b want 08/3/1", gnt, gnt_idx, gnt_valid); end
    rst = 1'b1; req = 8'h88; tick();
    rst = 1'b0;
    total++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0) begin bad++; $display("FAIL rmg_drop gnt=%h idx=%0d valid=%b want 00/0/0", gnt, gnt_idx, gnt_valid); end
    tick();
    total++;
    if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin bad++; $display("FAIL rmg_ptr0 gnt=%h idx=%0d want 08/3", gnt, gnt_idx); end
  endtask
  task automatic test_single();
    do_reset();
    req = 8'h01; tick();
    total++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_valid !== 1'b1) begin bad++; $display("FAIL single_grant gnt=%h idx=%0d valid=%b want 01/0/1", gnt, gnt_idx, gnt_valid); end
    done = 1'b1; tick();
    done = 1'b0;
    total++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd0) begin bad++; $display("FAIL single_gap gnt=%h idx=%0d valid=%b want 00/0/0", gnt, gnt_idx, gnt_valid); end
    tick();
    total++;
    if (gnt !== 8'h01 || gnt_valid !== 1'b1) begin bad++; $display("FAIL single_regrant gnt=%h valid=%b want 01/1", gnt, gnt_valid); end
  endtask
  task automatic test_rotation();
    do_reset();
    req = 8'hFF; tick();
    total++;
    if (gnt !== 8'h01) begin bad++; $display("FAIL rot_start gnt=%h want 01", gnt); end
    done = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      total++;
      if (gnt_idx !== 3'(i % 8) || gnt !== 8'h01 << (i % 8) || gnt_valid !== 1'b1) begin
        bad++;
        $display("FAIL rot_step%0d gnt=%h idx=%0d want %h/%0d", i, gnt, gnt_idx, 8'h01 << (i % 8), i % 8);
      end
    end
    done = 1'b0; req = 8'h00; tick();
  endtask
  task automatic test_wrap_skip();
    do_reset();
    req = 8'h20; tick();
    done = 1'b1; req = 8'h00; tick();
    done = 1'b0;
    total++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin bad++; $display("FAIL wrap_idle gnt=%h valid=%b want 00/0", gnt, gnt_valid); end
    req = 8'h43; tick();
    total++;
    if (gnt_idx !== 3'd6 || gnt !== 8'h40) begin bad++; $display("FAIL wrap_6 gnt=%h idx=%0d want 40/6", gnt, gnt_idx); end
    done = 1'b1; tick();
    total++;
    if (gnt_idx !== 3'd0 || gnt !== 8'h01) begin bad++; $display("FAIL wrap_0 gnt=%h idx=%0d want 01/0", gnt, gnt_idx); end
    tick();
    total++;
    if (gnt_idx !== 3'd1 || gnt !== 8'h02) begin bad++; $display("FAIL wrap_1 gnt=%h idx=%0d want 02/1", gnt, gnt_idx); end
    done = 1'b0; req = 8'h00; tick();
  endtask
  task automatic test_drop();
    do_reset();
    req = 8'h04; tick();
    total++;
    if (gnt !== 8'h04) begin bad++; $display("FAIL drop_own2 gnt=%h want 04", gnt); end
    req = 8'h18; tick();
    total++;
    if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin bad++; $display("FAIL drop_b2b gnt=%h idx=%0d want 08/3", gnt, gnt_idx); end
    req = 8'h00; tick();
    done = 1'b1; tick();
    total++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || gnt_idx !== 3'd3) begin bad++; $display("FAIL drop_idle_done gnt=%h idx=%0d valid=%b want 00/3/0", gnt, gnt_idx, gnt_valid); end
    req = 8'h10; tick();
    total++;
    if (gnt !== 8'h10 || gnt_idx !== 3'd4) begin bad++; $display("FAIL drop_done_ignored gnt=%h idx=%0d want 10/4", gnt, gnt_idx); end
    done = 1'b0; req = 8'h00; tick();
  endtask
  task automatic test_hold();
    do_reset();
    req = 8'h81; tick();
    `ifdef ARB_TIMEOUT_EN
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (gnt !== 8'h01 || timeout !== 1'b0) begin bad++; $display("FAIL tmo_hold%0d gnt=%h tmo=%b want 01/0", i, gnt, timeout); end
      if (i < 4) tick();
    end
    tick();
    total++;
    if (gnt !== 8'h80 || timeout !== 1'b1) begin bad++; $display("FAIL tmo_force gnt=%h tmo=%b want 80/1", gnt, timeout); end
    tick();
    total++;
    if (gnt !== 8'h80 || timeout !== 1'b0) begin bad++; $display("FAIL tmo_pulse gnt=%h tmo=%b want 80/0", gnt, timeout); end
    `else
    for (int i = 1; i <= 20; i++) begin
      if (i == 5) req = 8'h83;
      tick();
      total++;
      if (gnt !== 8'h01 || timeout !== 1'b0 || gnt_valid !== 1'b1) begin bad++; $display("FAIL hold%0d gnt=%h tmo=%b want 01/0", i, gnt, timeout); end
    end
    `endif
    req = 8'h00; tick();
  endtask
  initial begin
    rst = 1'b1; req = 8'h00; done = 1'b0;
    test_reset();
    test_reset_mid_grant();
    test_single();
    test_rotation();
    test_wrap_skip();
    test_drop();
    test_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
